bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 122 ++++++++++++
 tb/tb_bit_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one shift register plus a one-word hold buffer,
// streaming words back to back on x with no idle gap while input keeps coming.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             busy,
  output logic             last_bit,
  output logic [9:0]       words_sent
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_valid, w_hold_valid_nxt;
  logic [9:0]       r_words, w_words_nxt;

  logic             w_accept;
  logic             w_last;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_shifted;

  // Ready depends only on the hold flag, so upstream never sees a loop through din_valid.
  assign din_ready = !r_hold_valid;
  assign w_accept  = din_valid && !r_hold_valid;
  assign w_last    = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);

  assign w_cur_bit = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shift[WIDTH-1:1]};

  assign x          = (r_state == S_SHIFT) ? w_cur_bit : IDLE_BIT[0];
  assign busy       = (r_state == S_SHIFT);
  assign last_bit   = w_last;
  assign words_sent = r_words;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shift_nxt      = r_shift;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_words_nxt      = r_words;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (!w_last) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + 1'b1;
          if (w_accept) begin
            w_hold_nxt       = din;
            w_hold_valid_nxt = 1'b1;
          end
        end else begin
          w_words_nxt = r_words + 10'd1;
          w_cnt_nxt   = '0;
          if (r_hold_valid) begin
            w_shift_nxt      = r_hold;
            w_hold_valid_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = din;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_hold_valid <= 1'b0;
      r_words      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_words      <= w_words_nxt;
    end
  end

  // NOTE: the hold data register is left out of reset; its contents are
  // meaningless unless r_hold_valid is set, and that flag is reset.
  always_ff @(posedge clk) begin
    r_hold <= w_hold_nxt;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first instance and an LSB-first
// instance share clock and reset; each scenario checks against hand-computed values.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       x;
  logic       busy;
  logic       last_bit;
  logic [9:0] words_sent;

  logic [7:0] l_din;
  logic       l_din_valid;
  logic       l_din_ready;
  logic       l_x;
  logic       l_busy;
  logic       l_last_bit;
  logic [9:0] l_words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .x          (x),
    .busy       (busy),
    .last_bit   (last_bit),
    .words_sent (words_sent)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (l_din),
    .din_valid  (l_din_valid),
    .din_ready  (l_din_ready),
    .x          (l_x),
    .busy       (l_busy),
    .last_bit   (l_last_bit),
    .words_sent (l_words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    din_valid   = 1'b0;
    l_din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    din         = 8'hFF;
    din_valid   = 1'b1;
    l_din       = 8'hFF;
    l_din_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL reset_x got=%b exp=1", x); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (last_bit !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", last_bit); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
    n_checks++; if (words_sent !== 10'd0) begin n_fail++; $display("FAIL reset_words got=%0d exp=0", words_sent); end
    n_checks++; if (l_x !== 1'b1) begin n_fail++; $display("FAIL reset_lsb_x got=%b exp=1", l_x); end
    rst         = 1'b0;
    din_valid   = 1'b0;
    l_din_valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_xfer_busy got=%b exp=0", busy); end
    n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL reset_no_xfer_x got=%b exp=1", x); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_bits;
    exp_bits = 8'b0100_1010;
    do_reset();
    din       = exp_bits;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (x !== exp_bits[7-i]) begin n_fail++; $display("FAIL single_x bit%0d got=%b exp=%b", i, x, exp_bits[7-i]); end
      n_checks++; if (last_bit !== (i == 7)) begin n_fail++; $display("FAIL single_last bit%0d got=%b exp=%b", i, last_bit, (i == 7)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy bit%0d got=%b exp=1", i, busy); end
      tick();
    end
    n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL single_idle_x got=%b exp=1", x); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    n_checks++; if (last_bit !== 1'b0) begin n_fail++; $display("FAIL single_idle_last got=%b exp=0", last_bit); end
    n_checks++; if (words_sent !== 10'd1) begin n_fail++; $display("FAIL single_words got=%0d exp=1", words_sent); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w [3];
    logic [23:0] stream;
    logic        rdy;
    logic        exp_rdy;
    int          k;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hF0;
    stream = {8'hA5, 8'h3C, 8'hF0};
    do_reset();
    din       = w[0];
    din_valid = 1'b1;
    tick();
    k   = 1;
    din = w[1];
    for (int b = 0; b < 24; b++) begin
      // Hold is empty only on the first bit of each word (and once input runs dry).
      exp_rdy = (b == 0) || (b == 8) || (b >= 16);
      n_checks++; if (x !== stream[23-b]) begin n_fail++; $display("FAIL b2b_x bit%0d got=%b exp=%b", b, x, stream[23-b]); end
      n_checks++; if (din_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready bit%0d got=%b exp=%b", b, din_ready, exp_rdy); end
      n_checks++; if (last_bit !== ((b % 8) == 7)) begin n_fail++; $display("FAIL b2b_last bit%0d got=%b exp=%b", b, last_bit, ((b % 8) == 7)); end
      rdy = din_ready;
      tick();
      if (din_valid && rdy) begin
        k++;
        if (k < 3) din = w[k];
        else din_valid = 1'b0;
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
    n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL b2b_end_x got=%b exp=1", x); end
    n_checks++; if (words_sent !== 10'd3) begin n_fail++; $display("FAIL b2b_words got=%0d exp=3", words_sent); end
  endtask

  task automatic test_lsb_first();
    do_reset();
    l_din       = 8'h01;
    l_din_valid = 1'b1;
    tick();
    l_din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (l_x !== (i == 0)) begin n_fail++; $display("FAIL lsb_x bit%0d got=%b exp=%b", i, l_x, (i == 0)); end
      n_checks++; if (l_last_bit !== (i == 7)) begin n_fail++; $display("FAIL lsb_last bit%0d got=%b exp=%b", i, l_last_bit, (i == 7)); end
      tick();
    end
    n_checks++; if (l_busy !== 1'b0) begin n_fail++; $display("FAIL lsb_idle_busy got=%b exp=0", l_busy); end
    n_checks++; if (l_x !== 1'b1) begin n_fail++; $display("FAIL lsb_idle_x got=%b exp=1", l_x); end
    n_checks++; if (l_words_sent !== 10'd1) begin n_fail++; $display("FAIL lsb_words got=%0d exp=1", l_words_sent); end
  endtask

  task automatic test_mid_word_reset();
    do_reset();
    din       = 8'h00;
    din_valid = 1'b1;
    tick();
    din = 8'hFF;
    tick();
    din_valid = 1'b0;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_hold_ready got=%b exp=0", din_ready); end
    tick();
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_bit4_busy got=%b exp=1", busy); end
    n_checks++; if (x !== 1'b0) begin n_fail++; $display("FAIL midrst_bit4_x got=%b exp=0", x); end
    rst       = 1'b1;
    din_valid = 1'b1;
    tick();
    n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL midrst_x got=%b exp=1", x); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", din_ready); end
    n_checks++; if (words_sent !== 10'd0) begin n_fail++; $display("FAIL midrst_words got=%0d exp=0", words_sent); end
    rst       = 1'b0;
    din_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_after_busy got=%b exp=0", busy); end
    n_checks++; if (words_sent !== 10'd0) begin n_fail++; $display("FAIL midrst_after_words got=%0d exp=0", words_sent); end
  endtask

  // Streams n words back to back, then waits for the line to go idle; a blown
  // cycle budget is reported as a failure.
  task automatic send_words(input int n, input string tag);
    int  acc;
    int  cyc;
    logic rdy;
    acc = 0;
    cyc = 0;
    din       = 8'h5A;
    din_valid = 1'b1;
    while (acc < n && cyc < 12000) begin
      rdy = din_ready;
      tick();
      cyc++;
      if (rdy) acc++;
      if (acc == n) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    while (busy && cyc < 12000) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc >= 12000) begin n_fail++; $display("FAIL %s_timeout accepted=%0d exp=%0d", tag, acc, n); end
  endtask

  task automatic test_wrap();
    do_reset();
    send_words(1023, "wrap1023");
    n_checks++; if (words_sent !== 10'd1023) begin n_fail++; $display("FAIL wrap_1023 got=%0d exp=1023", words_sent); end
    send_words(1, "wrap1024");
    n_checks++; if (words_sent !== 10'd0) begin n_fail++; $display("FAIL wrap_1024 got=%0d exp=0", words_sent); end
    send_words(1, "wrap1025");
    n_checks++; if (words_sent !== 10'd1) begin n_fail++; $display("FAIL wrap_1025 got=%0d exp=1", words_sent); end
  endtask

  initial begin
    rst         = 1'b1;
    din         = '0;
    din_valid   = 1'b0;
    l_din       = '0;
    l_din_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_mid_word_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
